// File: rtl/fft_frame_sequencer_if.sv
// fft_frame_sequencer_if: sample, FFT and power-bin signals of the frame sequencer
interface fft_frame_sequencer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                         enable;
    logic                         sample_valid;
    logic signed [DATA_WIDTH-1:0] sample_data;
    logic                         sample_ready;
    logic                         fft_valid_in;
    logic [DATA_WIDTH-1:0]        fft_real_in;
    logic [DATA_WIDTH-1:0]        fft_imag_in;
    logic                         fft_ready;
    logic                         fft_valid_out;
    logic signed [DATA_WIDTH-1:0] fft_real_out;
    logic signed [DATA_WIDTH-1:0] fft_imag_out;
    logic                         bin_valid;
    logic [4:0]                   bin_index;
    logic [2*DATA_WIDTH-1:0]      bin_power;
    logic                         frame_done;
    logic [7:0]                   overrun_count;

    modport master (
        input  enable, sample_valid, sample_data, fft_ready, fft_valid_out, fft_real_out, fft_imag_out,
        output sample_ready, fft_valid_in, fft_real_in, fft_imag_in, bin_valid, bin_index, bin_power,
               frame_done, overrun_count
    );

    modport slave (
        output enable, sample_valid, sample_data, fft_ready, fft_valid_out, fft_real_out, fft_imag_out,
        input  sample_ready, fft_valid_in, fft_real_in, fft_imag_in, bin_valid, bin_index, bin_power,
               frame_done, overrun_count
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: buffers samples, feeds overlapping frames to the FFT, emits power bins
module fft_frame_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int FFT_SIZE   = 32,
    parameter int HOP        = 16,
    parameter int BUF_DEPTH  = 64,
    parameter int OUT_BINS   = 17
) (
    input logic                   clock,
    input logic                   reset,
    fft_frame_sequencer_if.master bus
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int FW = $clog2(FFT_SIZE) + 1;
    localparam int CW = $clog2(FFT_SIZE);

    typedef enum logic [1:0] {FILL, WAIT, FEED, COLLECT} state_t;

    state_t                        state;
    logic [AW:0]                   wr_ptr;
    logic [AW:0]                   frame_base;
    logic [AW:0]                   occupancy;
    logic [FW-1:0]                 feed_cnt;
    logic [CW-1:0]                 bin_cnt;
    logic [AW-1:0]                 rd_addr;
    logic [DATA_WIDTH-1:0]         buffer [BUF_DEPTH];
    logic                          accept;
    logic                          have_frame;
    logic signed [2*DATA_WIDTH-1:0] re_sq;
    logic signed [2*DATA_WIDTH-1:0] im_sq;

    assign occupancy        = wr_ptr - frame_base;
    assign bus.sample_ready = occupancy < (AW+1)'(BUF_DEPTH);
    assign accept           = bus.sample_valid && bus.sample_ready;
    assign have_frame       = occupancy >= (AW+1)'(FFT_SIZE);
    assign rd_addr          = frame_base[AW-1:0] + AW'(feed_cnt);
    assign re_sq            = (2*DATA_WIDTH)'(bus.fft_real_out) * (2*DATA_WIDTH)'(bus.fft_real_out);
    assign im_sq            = (2*DATA_WIDTH)'(bus.fft_imag_out) * (2*DATA_WIDTH)'(bus.fft_imag_out);
    assign bus.fft_imag_in  = '0;

    // Sample storage; unreset because only entries below wr_ptr are ever read
    always_ff @(posedge clock)
        if (accept) buffer[wr_ptr[AW-1:0]] <= bus.sample_data;

    // Write pointer and saturating count of samples dropped while the buffer is full
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            wr_ptr            <= '0;
            bus.overrun_count <= '0;
        end else if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
        end else if (bus.sample_valid && bus.overrun_count != 8'hFF) begin
            bus.overrun_count <= bus.overrun_count + 1'b1;
        end

    // Frame FSM: wait for a full frame, stream it to the FFT, then square and forward the returned bins
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state            <= FILL;
            frame_base       <= '0;
            feed_cnt         <= '0;
            bin_cnt          <= '0;
            bus.fft_valid_in <= 1'b0;
            bus.fft_real_in  <= '0;
            bus.bin_valid    <= 1'b0;
            bus.bin_index    <= '0;
            bus.bin_power    <= '0;
            bus.frame_done   <= 1'b0;
        end else begin
            bus.bin_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            case (state)
                FILL: if (have_frame) state <= WAIT;
                WAIT: if (bus.enable && bus.fft_ready && have_frame) begin
                    state            <= FEED;
                    bus.fft_valid_in <= 1'b1;
                    bus.fft_real_in  <= buffer[rd_addr];
                    feed_cnt         <= FW'(1);
                end
                FEED: if (feed_cnt == FW'(FFT_SIZE)) begin
                    bus.fft_valid_in <= 1'b0;
                    frame_base       <= frame_base + (AW+1)'(HOP);
                    feed_cnt         <= '0;
                    state            <= COLLECT;
                end else begin
                    bus.fft_real_in <= buffer[rd_addr];
                    feed_cnt        <= feed_cnt + 1'b1;
                end
                COLLECT: if (bus.fft_valid_out) begin
                    if ({1'b0, bin_cnt} < (CW+1)'(OUT_BINS)) begin
                        bus.bin_valid <= 1'b1;
                        bus.bin_index <= 5'(bin_cnt);
                        bus.bin_power <= $unsigned(re_sq) + $unsigned(im_sq);
                    end
                    bin_cnt <= bin_cnt + 1'b1;
                    if (bin_cnt == CW'(FFT_SIZE - 1)) begin
                        bin_cnt        <= '0;
                        bus.frame_done <= 1'b1;
                        state          <= WAIT;
                    end
                end
                default: state <= FILL;
            endcase
        end
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: directed and table-driven checks of the frame sequencer with a stub FFT
module tb_fft_frame_sequencer;
    typedef struct {
        logic signed [15:0] re;
        logic signed [15:0] im;
        logic               valid;
        logic [31:0]        power;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_fed = 0;
    int   n_done = 0;
    int   imag_bad = 0;
    int   cyc = 0;
    logic [15:0] fed_q[$];
    int          fed_cyc_q[$];
    logic [4:0]  bidx_q[$];
    logic [31:0] bpow_q[$];
    logic signed [15:0] resp_re [32];
    logic signed [15:0] resp_im [32];
    vec_t tbl [32];

    fft_frame_sequencer_if #(.DATA_WIDTH(16)) bus ();

    fft_frame_sequencer dut (.clock(clock), .reset(reset), .bus(bus.master));

    always #5 clock = ~clock;

    initial forever begin
        @(negedge clock);
        cyc++;
        if (bus.fft_valid_in) begin
            n_fed++;
            fed_q.push_back(bus.fft_real_in);
            fed_cyc_q.push_back(cyc);
            if (bus.fft_imag_in != 16'd0) imag_bad++;
        end
        if (bus.frame_done) n_done++;
        if (bus.bin_valid) begin
            bidx_q.push_back(bus.bin_index);
            bpow_q.push_back(bus.bin_power);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push(input logic [15:0] d, input int spacing);
        bus.sample_valid = 1'b1;
        bus.sample_data  = d;
        tick(1);
        bus.sample_valid = 1'b0;
        tick(spacing - 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic wait_fed(input int target);
        int t = 0;
        while (n_fed < target && t < 2000) begin
            tick(1);
            t++;
        end
        if (n_fed < target) chk("wait_fed timeout", 64'(n_fed), 64'(target));
    endtask

    task automatic respond(input int gap);
        for (int k = 0; k < 32; k++) begin
            bus.fft_valid_out = 1'b1;
            bus.fft_real_out  = resp_re[k];
            bus.fft_imag_out  = resp_im[k];
            tick(1);
            bus.fft_valid_out = 1'b0;
            tick(gap);
        end
        tick(2);
    endtask

    initial begin
        int f0, b0, d0, base, beats;
        tbl[0] = '{16'sd256, 16'sd0, 1'b1, 32'd65536};
        tbl[1] = '{-16'sd1, 16'sd0, 1'b1, 32'd1};
        tbl[2] = '{16'sd3, 16'sd4, 1'b1, 32'd25};
        tbl[3] = '{-16'sd32768, -16'sd32768, 1'b1, 32'h8000_0000};
        tbl[4] = '{16'sd32767, 16'sd0, 1'b1, 32'h3FFF_0001};
        tbl[5] = '{-16'sd32768, 16'sd32767, 1'b1, 32'h7FFF_0001};
        tbl[6] = '{16'sd0, -16'sd100, 1'b1, 32'd10000};
        tbl[7] = '{16'sd1000, -16'sd1000, 1'b1, 32'd2000000};
        for (int k = 8; k < 32; k++) begin
            tbl[k].re    = 16'(k);
            tbl[k].im    = 16'(-k);
            tbl[k].valid = k < 17;
            tbl[k].power = 32'(2 * k * k);
        end
        for (int k = 0; k < 32; k++) begin
            resp_re[k] = 16'sd0;
            resp_im[k] = 16'sd0;
        end
        bus.enable        = 1'b1;
        bus.sample_valid  = 1'b0;
        bus.sample_data   = '0;
        bus.fft_ready     = 1'b1;
        bus.fft_valid_out = 1'b0;
        bus.fft_real_out  = '0;
        bus.fft_imag_out  = '0;

        // reset state
        do_reset();
        chk("rst sample_ready", bus.sample_ready, 1);
        chk("rst fft_valid_in", bus.fft_valid_in, 0);
        chk("rst fft_real_in", bus.fft_real_in, 0);
        chk("rst bin_valid", bus.bin_valid, 0);
        chk("rst bin_power", bus.bin_power, 0);
        chk("rst frame_done", bus.frame_done, 0);
        chk("rst overrun", bus.overrun_count, 0);

        // DC frame: 32 x 0x0100, scaled FFT returns 256 in bin 0
        f0 = fed_q.size(); b0 = bidx_q.size(); d0 = n_done;
        for (int i = 0; i < 32; i++) push(16'h0100, 8);
        wait_fed(32);
        tick(3);
        chk("dc feed count", 64'(n_fed), 32);
        for (int i = 0; i < 32; i++) chk("dc feed data", fed_q[f0 + i], 16'h0100);
        chk("dc no gaps", 64'(fed_cyc_q[f0 + 31] - fed_cyc_q[f0]), 31);
        resp_re[0] = 16'sd256;
        respond(0);
        resp_re[0] = 16'sd0;
        chk("dc bin count", 64'(bidx_q.size() - b0), 17);
        for (int k = 0; k < 17; k++) begin
            chk("dc bin index", bidx_q[b0 + k], 64'(k));
            chk("dc bin power", bpow_q[b0 + k], k == 0 ? 64'd65536 : 64'd0);
        end
        chk("dc frame_done", 64'(n_done - d0), 1);

        // table-driven bins with one-cycle gaps between FFT output beats
        do_reset();
        for (int i = 0; i < 32; i++) push(16'(i), 1);
        wait_fed(n_fed + 32);
        tick(3);
        for (int k = 0; k < 32; k++) begin
            bus.fft_valid_out = 1'b1;
            bus.fft_real_out  = tbl[k].re;
            bus.fft_imag_out  = tbl[k].im;
            tick(1);
            bus.fft_valid_out = 1'b0;
            chk($sformatf("tbl bin_valid %0d", k), bus.bin_valid, tbl[k].valid);
            if (tbl[k].valid) begin
                chk($sformatf("tbl bin_index %0d", k), bus.bin_index, 64'(k));
                chk($sformatf("tbl bin_power %0d", k), bus.bin_power, tbl[k].power);
            end
            chk($sformatf("tbl frame_done %0d", k), bus.frame_done, k == 31);
            tick(1);
            chk("tbl gap bin_valid", bus.bin_valid, 0);
        end

        // ramp 0..47 at one sample per 8 clocks: two overlapping frames
        do_reset();
        f0 = fed_q.size(); d0 = n_done; base = n_fed;
        fork
            for (int i = 0; i < 48; i++) push(16'(i), 8);
            for (int f = 0; f < 2; f++) begin
                wait_fed(base + 32 * (f + 1));
                tick(3);
                respond(0);
            end
        join
        tick(3);
        chk("ramp frames", 64'(n_done - d0), 2);
        for (int i = 0; i < 32; i++) chk("ramp frame0", fed_q[f0 + i], 64'(i));
        for (int i = 0; i < 32; i++) chk("ramp frame1", fed_q[f0 + 32 + i], 64'(16 + i));
        chk("ramp frame_base", dut.frame_base, 32);

        // enable dropped mid-feed: frame completes, then hold until enable returns
        do_reset();
        f0 = fed_q.size(); b0 = bidx_q.size(); d0 = n_done; base = n_fed;
        for (int i = 0; i < 32; i++) push(16'(i), 1);
        wait_fed(base + 5);
        bus.enable = 1'b0;
        for (int i = 32; i < 48; i++) push(16'(i), 1);
        wait_fed(base + 32);
        tick(3);
        respond(0);
        chk("en beats", 64'(n_fed - base), 32);
        chk("en bins", 64'(bidx_q.size() - b0), 17);
        chk("en frame_done", 64'(n_done - d0), 1);
        tick(100);
        chk("en held", 64'(n_fed - base), 32);
        bus.enable = 1'b1;
        wait_fed(base + 64);
        for (int i = 0; i < 32; i++) chk("en resumed data", fed_q[f0 + 32 + i], 64'(16 + i));
        tick(3);
        respond(0);

        // overrun with FFT never ready
        do_reset();
        base = n_fed;
        bus.fft_ready = 1'b0;
        for (int i = 0; i < 70; i++) begin
            chk($sformatf("ovr sample_ready %0d", i), bus.sample_ready, i < 64);
            push(16'h0AAA, 1);
        end
        chk("ovr count", bus.overrun_count, 6);
        chk("ovr no feed", 64'(n_fed - base), 0);
        chk("ovr ready low", bus.sample_ready, 0);

        // reset on feed beat 10 discards everything
        bus.fft_ready = 1'b1;
        beats = 0;
        for (int t = 0; t < 100 && beats < 11; t++) begin
            tick(1);
            if (bus.fft_valid_in) beats++;
        end
        chk("rst mid beat reached", 64'(beats), 11);
        reset = 1'b1;
        #1;
        chk("rst mid fft_valid_in", bus.fft_valid_in, 0);
        chk("rst mid sample_ready", bus.sample_ready, 1);
        chk("rst mid overrun", bus.overrun_count, 0);
        chk("rst mid bin_valid", bus.bin_valid, 0);
        tick(2);
        reset = 1'b0;
        tick(1);
        f0 = fed_q.size();
        base = n_fed;
        for (int i = 0; i < 32; i++) push(16'h2000 + 16'(i), 1);
        wait_fed(base + 32);
        for (int i = 0; i < 32; i++) chk("rst post data", fed_q[f0 + i], 64'(16'h2000 + 16'(i)));
        tick(3);
        respond(0);
        chk("fft_imag_in zero", 64'(imag_bad), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
